// File: rtl/pwm_fade_sequencer.sv
// pwm_fade_sequencer: ramps the PWM duty toward a requested target one step at a time,
// only changing duty on PWM period boundaries so the comparator never sees a mid-period edit.
module pwm_fade_sequencer #(
  parameter int WIDTH = 8,
  parameter int INT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             period_tick,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_target,
  input  logic [WIDTH-1:0] cfg_step,
  input  logic [INT_W-1:0] cfg_interval,
  input  logic             abort,
  output logic [WIDTH-1:0] duty,
  output logic             busy,
  output logic             done
);
  typedef enum logic {IDLE, RAMP} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] duty_n, tgt, tgt_n, stp, stp_n, nxt;
  logic [INT_W-1:0] intv, intv_n, cnt, cnt_n;
  logic [WIDTH:0] sum, diff;
  logic done_n;
  assign cfg_ready = (state == IDLE) && ena;
  assign busy = (state == RAMP);
  // one extra bit catches carry past full scale and borrow below zero
  assign sum = {1'b0, duty} + {1'b0, stp};
  assign diff = {1'b0, duty} - {1'b0, stp};
  always_comb begin
    nxt = (duty < tgt) ? ((sum > {1'b0, tgt}) ? tgt : sum[WIDTH-1:0])
                       : ((diff[WIDTH] || diff[WIDTH-1:0] < tgt) ? tgt : diff[WIDTH-1:0]);
    state_n = state;
    duty_n = duty;
    tgt_n = tgt;
    stp_n = stp;
    intv_n = intv;
    cnt_n = cnt;
    done_n = 1'b0;
    if (cfg_valid && cfg_ready) begin
      tgt_n = cfg_target;
      stp_n = (cfg_step == '0) ? WIDTH'(1) : cfg_step;
      intv_n = cfg_interval;
      cnt_n = cfg_interval;
      state_n = (cfg_target == duty) ? IDLE : RAMP;
      done_n = (cfg_target == duty);
    end else if (state == RAMP && ena) begin
      if (abort) state_n = IDLE;
      else if (period_tick) begin
        if (cnt == '0) begin
          duty_n = nxt;
          cnt_n = intv;
          if (nxt == tgt) begin
            state_n = IDLE;
            done_n = 1'b1;
          end
        end else cnt_n = cnt - INT_W'(1);
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      duty <= '0;
      tgt <= '0;
      stp <= WIDTH'(1);
      intv <= '0;
      cnt <= '0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      duty <= duty_n;
      tgt <= tgt_n;
      stp <= stp_n;
      intv <= intv_n;
      cnt <= cnt_n;
      done <= done_n;
    end
  end
endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// tb_pwm_fade_sequencer: directed scenarios plus random traffic, checked against a
// tick-counting reference model of the fade sequencer.
module tb_pwm_fade_sequencer;
  localparam int W = 8;
  localparam int IW = 4;
  logic clk = 0, rst_n = 1, ena = 0, period_tick = 0, cfg_valid = 0, abort = 0;
  logic [W-1:0] cfg_target = 0, cfg_step = 0;
  logic [IW-1:0] cfg_interval = 0;
  logic cfg_ready, busy, done;
  logic [W-1:0] duty;
  int vec = 0, err = 0;
  int m_duty = 0, m_tgt = 0, m_stp = 1, m_int = 0, m_ticks = 0;
  bit m_busy = 0, m_done = 0;

  always #5 clk = ~clk;

  pwm_fade_sequencer #(.WIDTH(W), .INT_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .period_tick(period_tick),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_target(cfg_target),
    .cfg_step(cfg_step), .cfg_interval(cfg_interval), .abort(abort),
    .duty(duty), .busy(busy), .done(done)
  );

  // drive one cycle, advance the model by counting ticks since the request
  task automatic cyc(input logic t, input logic v, input logic a, input logic e);
    period_tick = t; cfg_valid = v; abort = a; ena = e;
    @(posedge clk);
    m_done = 0;
    if (e) begin
      if (!m_busy) begin
        if (v) begin
          m_tgt = cfg_target; m_stp = (cfg_step == 0) ? 1 : cfg_step;
          m_int = cfg_interval; m_ticks = 0;
          if (m_tgt == m_duty) m_done = 1; else m_busy = 1;
        end
      end else if (a) m_busy = 0;
      else if (t) begin
        m_ticks++;
        if (m_ticks % (m_int + 1) == 0) begin
          if (m_duty < m_tgt) m_duty = (m_duty + m_stp > m_tgt) ? m_tgt : m_duty + m_stp;
          else m_duty = (m_duty - m_stp < m_tgt) ? m_tgt : m_duty - m_stp;
          if (m_duty == m_tgt) begin m_busy = 0; m_done = 1; end
        end
      end
    end
    #1;
  endtask

  task automatic set_cfg(input int t, input int s, input int i);
    cfg_target = W'(t); cfg_step = W'(s); cfg_interval = IW'(i);
  endtask

  task automatic test_reset();
    #2 rst_n = 0; ena = 1;
    #1;
    vec++;
    if (duty !== 0 || busy !== 0 || done !== 0) begin
      err++; $display("FAIL reset_async duty=%0d busy=%b done=%b want 0/0/0", duty, busy, done);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    vec++;
    if (cfg_ready !== 1 || duty !== 0 || busy !== 0 || done !== 0) begin
      err++; $display("FAIL reset_release ready=%b duty=%0d busy=%b done=%b want 1/0/0/0", cfg_ready, duty, busy, done);
    end
  endtask

  task automatic test_ramp_up();
    int exp_d[4] = '{3, 6, 9, 10};
    int dones = 0;
    set_cfg(10, 3, 0);
    cyc(0, 1, 0, 1);
    vec++;
    if (busy !== 1) begin err++; $display("FAIL ramp_up_busy got=%b want 1", busy); end
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 20; c++) begin
        cyc(c == 19, 0, 0, 1);
        dones += int'(done);
        vec++;
        if (duty !== m_duty || busy !== m_busy || done !== m_done || cfg_ready !== (!m_busy && ena)) begin
          err++; $display("FAIL ramp_up_model duty=%0d/%0d busy=%b/%b done=%b/%b", duty, m_duty, busy, m_busy, done, m_done);
        end
      end
      vec++;
      if (duty !== exp_d[k]) begin err++; $display("FAIL ramp_up_step%0d got=%0d want=%0d", k + 1, duty, exp_d[k]); end
    end
    cyc(0, 0, 0, 1);
    vec++;
    if (dones != 1 || busy !== 0 || done !== 0) begin
      err++; $display("FAIL ramp_up_done pulses=%0d busy=%b done=%b want 1/0/0", dones, busy, done);
    end
  endtask

  task automatic test_ramp_down();
    int exp_d[4] = '{200, 100, 100, 5};
    int dones = 0;
    set_cfg(200, 255, 0);
    cyc(0, 1, 0, 1);
    cyc(1, 0, 0, 1);
    cyc(0, 0, 0, 1);
    vec++;
    if (duty !== 200 || busy !== 0) begin err++; $display("FAIL ramp_down_setup got=%0d want=200", duty); end
    set_cfg(5, 100, 1);
    cyc(0, 1, 0, 1);
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 20; c++) begin
        cyc(c == 19, 0, 0, 1);
        dones += int'(done);
        vec++;
        if (duty !== m_duty || busy !== m_busy || done !== m_done) begin
          err++; $display("FAIL ramp_down_model duty=%0d/%0d busy=%b/%b done=%b/%b", duty, m_duty, busy, m_busy, done, m_done);
        end
      end
      vec++;
      if (duty !== exp_d[k]) begin err++; $display("FAIL ramp_down_tick%0d got=%0d want=%0d", k + 1, duty, exp_d[k]); end
    end
    vec++;
    if (dones != 1 || busy !== 0) begin err++; $display("FAIL ramp_down_done pulses=%0d busy=%b want 1/0", dones, busy); end
  endtask

  task automatic test_overflow();
    set_cfg(250, 255, 0);
    cyc(0, 1, 0, 1);
    cyc(1, 0, 0, 1);
    vec++;
    if (duty !== 250) begin err++; $display("FAIL overflow_setup got=%0d want=250", duty); end
    set_cfg(255, 200, 0);
    cyc(0, 1, 0, 1);
    cyc(1, 0, 0, 1);
    vec++;
    if (duty !== 255 || done !== 1 || busy !== 0) begin
      err++; $display("FAIL overflow_sat duty=%0d done=%b busy=%b want 255/1/0", duty, done, busy);
    end
    cyc(0, 0, 0, 1);
    cyc(0, 1, 0, 1);
    vec++;
    if (done !== 1 || busy !== 0 || duty !== 255) begin
      err++; $display("FAIL equal_target done=%b busy=%b duty=%0d want 1/0/255", done, busy, duty);
    end
    for (int c = 0; c < 4; c++) begin
      cyc(c == 1, 0, 0, 1);
      vec++;
      if (busy !== 0 || done !== 0 || duty !== 255) begin
        err++; $display("FAIL equal_after busy=%b done=%b duty=%0d want 0/0/255", busy, done, duty);
      end
    end
  endtask

  task automatic test_freeze_abort();
    set_cfg(0, 1, 0);
    cyc(0, 1, 0, 1);
    for (int c = 0; c < 12; c++) cyc(c % 4 == 3, 0, 0, 1);
    vec++;
    if (duty !== 252 || busy !== 1) begin err++; $display("FAIL freeze_setup duty=%0d busy=%b want 252/1", duty, busy); end
    for (int c = 0; c < 12; c++) begin
      cyc(c % 4 == 3, c == 5, c == 7, 0);
      vec++;
      if (duty !== 252 || cfg_ready !== 0 || busy !== 1 || done !== 0) begin
        err++; $display("FAIL freeze duty=%0d ready=%b busy=%b done=%b want 252/0/1/0", duty, cfg_ready, busy, done);
      end
    end
    cyc(1, 0, 1, 1);
    vec++;
    if (duty !== 252 || busy !== 0 || done !== 0 || cfg_ready !== 1) begin
      err++; $display("FAIL abort duty=%0d busy=%b done=%b ready=%b want 252/0/0/1", duty, busy, done, cfg_ready);
    end
    for (int c = 0; c < 4; c++) begin
      cyc(1, 0, c == 2, 1);
      vec++;
      if (duty !== 252 || busy !== 0 || done !== 0) begin
        err++; $display("FAIL abort_hold duty=%0d busy=%b done=%b want 252/0/0", duty, busy, done);
      end
    end
  endtask

  task automatic test_handshake();
    int acc = -1;
    set_cfg(240, 4, 0);
    cyc(0, 1, 0, 1);
    for (int c = 0; c < 100 && acc < 0; c++) begin
      bit was_ready;
      int cur;
      cfg_target = W'($urandom);
      cfg_step = W'(255);
      cur = cfg_target;
      was_ready = cfg_ready;
      cyc(c % 3 == 2, 1, 0, 1);
      if (was_ready) acc = cur;
      vec++;
      if (duty !== m_duty || busy !== m_busy || done !== m_done || cfg_ready !== !m_busy) begin
        err++; $display("FAIL handshake_model duty=%0d/%0d busy=%b/%b done=%b/%b", duty, m_duty, busy, m_busy, done, m_done);
      end
    end
    vec++;
    if (acc < 0) begin err++; $display("FAIL handshake_timeout ready never rose"); end
    else begin
      cfg_target = W'($urandom);
      cyc(0, 0, 0, 1);
      cyc(1, 0, 0, 1);
      cyc(0, 0, 0, 1);
      vec++;
      if (duty !== acc || busy !== 0) begin
        err++; $display("FAIL handshake_capture duty=%0d busy=%b want %0d/0", duty, busy, acc);
      end
    end
  endtask

  task automatic test_reset_mid();
    set_cfg(0, 1, 0);
    cyc(0, 1, 0, 1);
    cyc(1, 0, 0, 1);
    @(posedge clk);
    #3 rst_n = 0;
    #1;
    m_duty = 0; m_busy = 0; m_done = 0;
    vec++;
    if (duty !== 0 || busy !== 0 || done !== 0) begin
      err++; $display("FAIL reset_mid duty=%0d busy=%b done=%b want 0/0/0", duty, busy, done);
    end
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    vec++;
    if (cfg_ready !== 1 || duty !== 0 || done !== 0) begin
      err++; $display("FAIL reset_mid_release ready=%b duty=%0d done=%b want 1/0/0", cfg_ready, duty, done);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      cfg_target = W'($urandom);
      cfg_step = ($urandom_range(0, 3) == 0) ? W'(0) : W'($urandom_range(1, 60));
      cfg_interval = IW'($urandom_range(0, 3));
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 39) == 0, $urandom_range(0, 15) != 0);
      vec++;
      if (duty !== m_duty || busy !== m_busy || done !== m_done || cfg_ready !== (!m_busy && ena)) begin
        err++; $display("FAIL random c=%0d duty=%0d/%0d busy=%b/%b done=%b/%b ready=%b",
                        c, duty, m_duty, busy, m_busy, done, m_done, cfg_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_overflow();
    test_freeze_abort();
    test_handshake();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule

// File: doc/pwm_fade_sequencer.md
Name: pwm_fade_sequencer

Overview:
Controller that sequences the duty-cycle input of the 8-bit PWM core. It accepts a target duty, a step size and a step interval over a valid/ready handshake. It then ramps its duty output toward the target one step at a time. Steps occur only at PWM period boundaries, so the PWM comparator never sees a mid-period duty change.

Parameters:
WIDTH, 8, duty width (matches PWM core duty/compare width)
INT_W, 4, width of step-interval field

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  block enable; 0 freezes all state
period_tick  in  1  one-cycle pulse from PWM core at start of each PWM period (prescaler/duty counter wrap)
cfg_valid  in  1  new ramp request valid
cfg_ready  out  1  sequencer can accept request
cfg_target  in  WIDTH  target duty
cfg_step  in  WIDTH  duty increment per step; 0 treated as 1
cfg_interval  in  INT_W  PWM periods between steps minus 1
abort  in  1  stop ramp and hold current duty
duty  out  WIDTH  duty value driven to PWM comparator
busy  out  1  ramp in progress
done  out  1  one-cycle pulse when duty reaches target

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low on rst_n.
- Reset values: duty=0, busy=0, done=0, state IDLE, interval counter=0. cfg_ready follows the IDLE/ena rule below.
- Reset mid-ramp: all state returns to reset values immediately. No done pulse.
- States: IDLE, RAMP.
- cfg_ready = (state==IDLE) && ena. It is combinational from registered state.
- Transfer occurs on a rising edge with cfg_valid && cfg_ready.
- On transfer, capture target, step (0→1) and interval. Load the interval counter with cfg_interval.
- Transfer with cfg_target == duty: remain IDLE, busy stays 0, done pulses in the next cycle.
- Transfer with cfg_target != duty: go to RAMP, busy=1 from the next cycle.
- RAMP, on a cycle with ena=1 && period_tick=1 && abort=0:
  - If interval counter==0: apply one step and reload the counter with the captured interval.
  - Otherwise: decrement the counter.
- Step up (duty<target): duty_next = min(duty+step, target). Compute in WIDTH+1 bits; no wrap-around past 2^WIDTH-1.
- Step down (duty>target): duty_next = max(duty-step, target). Detect borrow; no wrap below 0.
- Completion: on the edge where duty becomes equal to target, state→IDLE, busy→0, done=1 for exactly one cycle. Registered, aligned with the new duty value.
- Step latency: duty updates on the edge that samples period_tick, so the new value is visible one cycle after the tick. Steps land every (cfg_interval+1) ticks; the first step lands on tick cfg_interval+1 after transfer.
- abort in RAMP: next edge → IDLE, busy=0, duty holds its current value, no done pulse.
- abort in IDLE: ignored.
- abort together with period_tick: abort wins, no step applied.
- ena=0: state, counter and duty all hold. period_tick, cfg_valid and abort are ignored. cfg_ready=0 and done=0.
- cfg_valid while busy: not accepted. Requester must hold cfg_valid until cfg_ready; the captured fields are those present on the transfer edge.
- Outputs duty, busy and done are registered; no combinational path from inputs to them.

Test Plan:
1. Reset: assert rst_n=0 asynchronously mid-cycle → duty=0, busy=0, done=0 immediately; cfg_ready=1 with ena=1 after release.
2. Ramp up: duty=0, target=10, step=3, interval=0, tick every 20 clk → duty 3,6,9,10 one cycle after ticks 1-4. done pulses once with duty=10; busy low afterwards.
3. Ramp down with interval: duty=200, target=5, step=100, interval=1 → duty=100 after tick 2, 5 after tick 4 (saturated, not 0). done once.
4. Overflow/equal: duty=250, target=255, step=200 → duty=255 after first tick, no wrap. Then request target=255 → done next cycle, busy never 1.
5. Freeze/abort: mid-ramp drive ena=0 across 3 ticks → duty unchanged, cfg_ready=0. Restore ena, then assert abort coincident with a tick → duty unchanged, IDLE, no done.
6. Handshake: cfg_valid held high during RAMP → no capture until cfg_ready=1. Captured target equals the value present on the accepting edge.
